// File: rtl/multicycle_core_if.sv
// Unified memory port of the multi-cycle core: request/ready handshake,
// one access in flight, address and write data held until ready.
interface multicycle_core_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core (lw, sw, R/I add/sub/slt/or/and, beq, jal)
// sharing one memory port for fetch and data; illegal encodings park in TRAP.
module multicycle_core #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              NREGS    = 32
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_core_if.master   mem,
    output logic                retire,
    output logic                trap,
    output logic [XLEN-1:0]     pc_out
);
    localparam int RW = $clog2(NREGS);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, oldpc_q, oldpc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d, mdr_q, mdr_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] rf_q [NREGS];

    logic            req_c, we_c, retire_c, rf_we;
    logic [XLEN-1:0] addr_c, wdata_c, rf_wdata;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [RW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_j;
    logic            f3_ok;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[15 +: RW];
    assign rs2    = ir_q[20 +: RW];
    assign rd     = ir_q[7 +: RW];
    assign imm_i  = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j  = {{(XLEN-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                    (funct3 == 3'b110) || (funct3 == 3'b111);
    assign rs1_val = (rs1 == '0) ? '0 : rf_q[rs1];
    assign rs2_val = (rs2 == '0) ? '0 : rf_q[rs2];

    function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic [XLEN-1:0] x,
                                            input logic [XLEN-1:0] y, input logic sub);
        logic [XLEN-1:0] r;
        r = '0;
        case (f3)
            3'b000:  r = sub ? (x - y) : (x + y);
            3'b010:  r = ($signed(x) < $signed(y)) ? XLEN'(1) : '0;
            3'b110:  r = x | y;
            3'b111:  r = x & y;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            oldpc_q  <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            oldpc_q  <= oldpc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
            trap_q   <= trap_d;
        end
    end

    // Register file is deliberately left out of reset; x0 is never written.
    always_ff @(posedge clk) begin
        if (rf_we && rd != '0) rf_q[rd] <= rf_wdata;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        oldpc_d  = oldpc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        trap_d   = trap_q;
        req_c    = 1'b0;
        we_c     = 1'b0;
        addr_c   = pc_q;
        wdata_c  = b_q;
        rf_we    = 1'b0;
        rf_wdata = aluout_q;
        retire_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_d    = mem.mem_rdata[31:0];
                    pc_d    = pc_q + XLEN'(4);
                    oldpc_d = pc_q;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d      = rs1_val;
                b_d      = rs2_val;
                aluout_d = oldpc_q + imm_b;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_REG:            state_d = f3_ok ? S_EXECR : S_TRAP;
                    OP_IMM:            state_d = f3_ok ? S_EXECI : S_TRAP;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
                if (state_d == S_TRAP) trap_d = 1'b1;
            end
            S_MEMADR: begin
                aluout_d = a_q + ((opcode == OP_STORE) ? imm_s : imm_i);
                state_d  = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                req_c  = 1'b1;
                addr_c = aluout_q;
                if (mem.mem_ready) begin
                    mdr_d   = mem.mem_rdata;
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                rf_we    = 1'b1;
                rf_wdata = mdr_q;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWRITE: begin
                req_c  = 1'b1;
                we_c   = 1'b1;
                addr_c = aluout_q;
                if (mem.mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXECR: begin
                aluout_d = alu(funct3, a_q, b_q, ir_q[30]);
                state_d  = S_ALUWB;
            end
            S_EXECI: begin
                aluout_d = alu(funct3, a_q, imm_i, 1'b0);
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we    = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                if (a_q == b_q) pc_d = aluout_q;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                rf_we    = 1'b1;
                rf_wdata = pc_q;
                pc_d     = oldpc_q + imm_j;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Gating by reset drops an in-flight request without waiting for an edge.
    assign mem.mem_req   = req_c & ~reset;
    assign mem.mem_we    = we_c;
    assign mem.mem_addr  = addr_c;
    assign mem.mem_wdata = wdata_c;
    assign retire        = retire_c & ~reset;
    assign trap          = trap_q;
    assign pc_out        = pc_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Directed program run against a stalling memory model; expected bus
// transactions and per-instruction latencies are queued and checked by a monitor.
module tb_multicycle_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        retire, trap;
    logic [31:0] pc_out;

    multicycle_core_if #(.XLEN(32)) mem ();

    multicycle_core #(.XLEN(32), .RESET_PC(32'h100), .NREGS(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .mem    (mem),
        .retire (retire),
        .trap   (trap),
        .pc_out (pc_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    int          lat_q[$];
    logic [31:0] ram [0:1023];
    int          total = 0;
    int          bad = 0;
    bit          hold_rd8 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    // lat < 0: no retire expected; lat == 0: retire expected, duration unchecked.
    task automatic step(input logic [31:0] addr, input logic [31:0] instr, input int lat);
        ram[addr[11:2]] = instr;
        exp_q.push_back('{we: 1'b0, addr: addr, data: 32'h0});
        if (lat >= 0) lat_q.push_back(lat);
    endtask
    task automatic exp_wr(input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back('{we: 1'b1, addr: addr, data: data});
    endtask
    task automatic exp_rd(input logic [31:0] addr);
        exp_q.push_back('{we: 1'b0, addr: addr, data: 32'h0});
    endtask

    // Memory responder: data accesses at address 8 wait 3 cycles (or forever
    // when hold_rd8 is set for reads); ready idles high when nothing is requested.
    int waitc = 0;
    bit prev_grant = 1'b0;
    always @(negedge clk) begin
        int need;
        mem.mem_ready = 1'b1;
        if (reset || prev_grant) waitc = 0;
        prev_grant = 1'b0;
        if (!reset && mem.mem_req) begin
            need = 0;
            if (mem.mem_addr == 32'h8) need = (hold_rd8 && !mem.mem_we) ? 1000000 : 3;
            if (waitc >= need) begin
                mem.mem_rdata = ram[mem.mem_addr[11:2]];
                if (mem.mem_we) ram[mem.mem_addr[11:2]] = mem.mem_wdata;
                prev_grant = 1'b1;
            end else begin
                mem.mem_ready = 1'b0;
                waitc++;
            end
        end
    end

    // Monitor: pops expected transactions/latencies as the DUT completes them.
    int          cyc = 0;
    int          last_ret = 0;
    bit          started = 1'b0;
    bit          in_stall = 1'b0;
    logic [31:0] st_addr, st_wdata;
    always @(negedge clk) begin
        txn_t e;
        int   l;
        #1;
        cyc++;
        if (reset) begin
            in_stall = 1'b0;
        end else begin
            if (!started && mem.mem_req) begin
                started  = 1'b1;
                last_ret = cyc - 1;
            end
            if (mem.mem_req) begin
                if (in_stall) begin
                    check("stall_addr", mem.mem_addr, st_addr);
                    if (mem.mem_we) check("stall_wdata", mem.mem_wdata, st_wdata);
                end
                if (!mem.mem_ready) begin
                    if (!in_stall) begin
                        st_addr  = mem.mem_addr;
                        st_wdata = mem.mem_wdata;
                    end
                    in_stall = 1'b1;
                end else begin
                    in_stall = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_txn_addr", mem.mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("txn_we", mem.mem_we, e.we);
                        check("txn_addr", mem.mem_addr, e.addr);
                        if (e.we) check("txn_wdata", mem.mem_wdata, e.data);
                    end
                end
            end
            if (retire) begin
                if (lat_q.size() == 0) begin
                    check("unexpected_retire_pc", pc_out, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    l = lat_q.pop_front();
                    if (l > 0) check("latency", cyc - last_ret, l);
                end
                last_ret = cyc;
            end
        end
    end

    initial begin
        int n;
        bit found;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        mem.mem_ready = 1'b0;
        mem.mem_rdata = 32'h0;

        step(32'h100, enc_i(-5, 0, 0, 1, 'h13), 4);           // addi x1,x0,-5
        step(32'h104, enc_i(7, 0, 0, 2, 'h13), 4);            // addi x2,x0,7
        step(32'h108, enc_r('h00, 2, 1, 0, 3), 4);            // add  x3 = 2
        step(32'h10C, enc_r('h20, 2, 1, 0, 4), 4);            // sub  x4 = -12
        step(32'h110, enc_r('h00, 2, 1, 2, 5), 4);            // slt  x5 = 1
        step(32'h114, enc_s(8, 3, 0), 7);  exp_wr(32'h8, 32'h2);
        step(32'h118, enc_i(8, 0, 2, 6, 'h03), 8);  exp_rd(32'h8);
        step(32'h11C, enc_s('h200, 4, 0), 4);  exp_wr(32'h200, 32'hFFFF_FFF4);
        step(32'h120, enc_s('h204, 5, 0), 4);  exp_wr(32'h204, 32'h1);
        step(32'h124, enc_s('h208, 6, 0), 4);  exp_wr(32'h208, 32'h2);
        step(32'h128, enc_b(8, 2, 1), 3);                     // beq x1,x2 not taken
        step(32'h12C, enc_j(-'h10C, 0), 0);                   // jal x0 -> 0x20
        step(32'h020, enc_b(-8, 0, 0), 3);                    // beq x0,x0,-8 -> 0x18
        step(32'h018, enc_j('h18, 0), 0);                     // jal x0 -> 0x30
        step(32'h030, enc_j('h40, 1), 0);                     // jal x1 -> 0x70
        step(32'h070, enc_s('h20C, 1, 0), 4);  exp_wr(32'h20C, 32'h34);
        step(32'h074, enc_s('h210, 0, 0), 4);  exp_wr(32'h210, 32'h0);
        step(32'h078, enc_i('hF0, 0, 6, 7, 'h13), 4);         // ori  x7 = 0xF0
        step(32'h07C, enc_i('h3C, 7, 7, 8, 'h13), 4);         // andi x8 = 0x30
        step(32'h080, enc_i('h35, 1, 2, 9, 'h13), 4);         // slti x9 = 1
        step(32'h084, enc_r('h00, 2, 7, 6, 10), 4);           // or   x10 = 0xF7
        step(32'h088, enc_r('h00, 8, 10, 7, 11), 4);          // and  x11 = 0x30
        step(32'h08C, enc_r('h00, 4, 2, 2, 12), 4);           // slt  x12 = 0 (7 < -12 signed)
        step(32'h090, enc_r('h00, 4, 4, 0, 13), 4);           // add  x13 = 0xFFFFFFE8
        step(32'h094, enc_s('h214, 7, 0), 4);  exp_wr(32'h214, 32'hF0);
        step(32'h098, enc_s('h218, 8, 0), 4);  exp_wr(32'h218, 32'h30);
        step(32'h09C, enc_s('h21C, 9, 0), 4);  exp_wr(32'h21C, 32'h1);
        step(32'h0A0, enc_s('h220, 10, 0), 4); exp_wr(32'h220, 32'hF7);
        step(32'h0A4, enc_s('h224, 11, 0), 4); exp_wr(32'h224, 32'h30);
        step(32'h0A8, enc_s('h228, 12, 0), 4); exp_wr(32'h228, 32'h0);
        step(32'h0AC, enc_s('h22C, 13, 0), 4); exp_wr(32'h22C, 32'hFFFF_FFE8);
        step(32'h0B0, 32'h0000_007F, -1);                     // illegal opcode

        repeat (3) begin
            @(negedge clk); #2;
            check("req_in_reset", mem.mem_req, 1'b0);
            check("retire_in_reset", retire, 1'b0);
        end
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (trap) break;
        end
        #2 check("trap_set", trap, 1'b1);
        n = 0;
        repeat (20) begin
            @(negedge clk); #2;
            if (mem.mem_req) n++;
        end
        check("req_after_trap", n, 0);
        check("txn_left", exp_q.size(), 0);
        check("retire_left", lat_q.size(), 0);

        hold_rd8 = 1'b1;
        ram[32'h100 >> 2] = enc_i(8, 0, 2, 6, 'h03);          // lw x6,8(x0), stalled forever
        exp_q.push_back('{we: 1'b0, addr: 32'h100, data: 32'h0});
        @(negedge clk); #3 reset = 1'b1;
        #1;
        check("trap_cleared", trap, 1'b0);
        check("pc_reset", pc_out, 32'h100);
        @(posedge clk); #1 reset = 1'b0;

        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk); #2;
            if (mem.mem_req && !mem.mem_we && mem.mem_addr == 32'h8) found = 1'b1;
        end
        check("reach_memread", found, 1'b1);
        repeat (2) @(negedge clk);
        #3 check("req_while_stalled", mem.mem_req, 1'b1);
        reset = 1'b1;
        #1;
        check("req_drop_on_reset", mem.mem_req, 1'b0);
        check("retire_on_reset", retire, 1'b0);
        repeat (2) @(negedge clk);
        check("txn_left_end", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
